// File: rtl/fetch_pkg.sv
// Shared widths, constants and the buffered-instruction payload type for the fetch stage.
package fetch_pkg;

    localparam int unsigned WORD_SIZE  = 32;
    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned INS_BYTES  = 4;
    localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [WORD_SIZE-1:0] pc;
        logic [WORD_SIZE-1:0] ins;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request/grant + response-valid bus between fetch and imem.
interface fetch_if
    import fetch_pkg::*;
#(
    parameter int unsigned WordSize = WORD_SIZE
) ();

    logic                req;
    logic [WordSize-1:0] addr;
    logic                gnt;
    logic                rvalid;
    logic [WordSize-1:0] rdata;

    modport master (output req, addr, input gnt, rvalid, rdata);
    modport slave  (input req, addr, output gnt, rvalid, rdata);

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; head is the registered entry at the read pointer.
module fetch_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 2
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [Width-1:0]           data,
    output logic [Width-1:0]           head,
    output logic [$clog2(Depth+1)-1:0] count
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wr_ptr;
    logic [PtrW-1:0]  rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !flush;
    assign do_pop  = pop && !flush && (count != '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= data;
                wr_ptr      <= wr_ptr + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PtrW'(1);
            end
            count <= count + CntW'(do_push) - CntW'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC generation, credit-limited imem requests, response buffering
// and redirect handling with squash of wrong-path responses.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned         WordSize    = WORD_SIZE,
    parameter logic [WordSize-1:0] ResetVector = '0,
    parameter int unsigned         FifoDepth   = FIFO_DEPTH
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                branch_taken,
    input  logic [WordSize-1:0] branch_addr,
    input  logic                stall,
    fetch_if.master             imem,
    output logic [WordSize-1:0] ins,
    output logic [WordSize-1:0] pc_out,
    output logic                ins_valid
);

    localparam int unsigned CntW = $clog2(FifoDepth + 1);
    localparam int unsigned SumW = CntW + 1;

    logic [WordSize-1:0] pc_q;
    logic [CntW-1:0]     drop_q;
    logic [CntW-1:0]     outstanding;
    logic [CntW-1:0]     resp_count;
    logic [WordSize-1:0] addr_head;
    logic                grant;
    logic                rsp_push;
    logic                rsp_pop;
    fetch_entry_t        rsp_in;
    fetch_entry_t        rsp_head;

    // Credit rule: in-flight plus buffered never exceeds the response FIFO depth.
    assign imem.req  = rstn && !branch_taken &&
                       ((SumW'(outstanding) + SumW'(resp_count)) < SumW'(FifoDepth));
    assign imem.addr = pc_q;
    assign grant     = imem.req && imem.gnt;

    assign rsp_push  = imem.rvalid && (drop_q == '0) && !branch_taken;
    assign rsp_in.pc  = addr_head;
    assign rsp_in.ins = imem.rdata;

    assign ins_valid = (resp_count != '0) && !branch_taken;
    assign rsp_pop   = ins_valid && !stall;
    assign ins       = rsp_head.ins;
    assign pc_out    = rsp_head.pc;

    // Outstanding requests are exactly the occupancy of the address FIFO.
    fetch_fifo #(.Width(WordSize), .Depth(FifoDepth)) u_addr_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (grant),
        .pop   (imem.rvalid),
        .flush (1'b0),
        .data  (pc_q),
        .head  (addr_head),
        .count (outstanding)
    );

    fetch_fifo #(.Width($bits(fetch_entry_t)), .Depth(FifoDepth)) u_rsp_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (rsp_push),
        .pop   (rsp_pop),
        .flush (branch_taken),
        .data  (rsp_in),
        .head  (rsp_head),
        .count (resp_count)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_q   <= ResetVector;
            drop_q <= '0;
        end else if (branch_taken) begin
            pc_q   <= branch_addr & ~WordSize'(INS_BYTES - 1);
            // drop is a subset of outstanding, so every response still in flight is squashed.
            drop_q <= outstanding - CntW'(imem.rvalid);
        end else begin
            if (grant) begin
                pc_q <= pc_q + WordSize'(INS_BYTES);
            end
            if (imem.rvalid && (drop_q != '0)) begin
                drop_q <= drop_q - CntW'(1);
            end
        end
    end

endmodule
